// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: constant-width math and the
// pointer increment that wraps at an arbitrary depth.
package fifo_pkg;

  function automatic int clog2(input int unsigned value);
    int          result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_sync_prog_if.sv
// Handshake/status bundle for fifo_sync_prog; master is the FIFO user,
// slave is the FIFO itself.
interface fifo_sync_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  import fifo_pkg::*;

  localparam int CNT_WIDTH = clog2(DEPTH + 1);

  logic                  clear_i;
  logic                  wen_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  ren_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic [CNT_WIDTH-1:0]  afull_thr_i;
  logic [CNT_WIDTH-1:0]  aempty_thr_i;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  overflow_o;
  logic                  underflow_o;
  logic                  err_clr_i;

  modport master (
    output clear_i, wen_i, data_i, ren_i, afull_thr_i, aempty_thr_i, err_clr_i,
    input  data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           cnt_o, overflow_o, underflow_o
  );

  modport slave (
    input  clear_i, wen_i, data_i, ren_i, afull_thr_i, aempty_thr_i, err_clr_i,
    output data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           cnt_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// registered read port; only the read register is reset, never the array.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: a same-address write (full with read+write) returns the old entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost flags and a
// registered read strobe. Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fifo_sync_prog_if.slave bus
);
  import fifo_pkg::*;

  localparam int CNT_WIDTH = clog2(DEPTH + 1);
  localparam int PTR_W     = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic                 r_valid;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_do_rd;
  logic w_do_wr;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_WIDTH'(DEPTH));
  assign w_rd_acc = bus.ren_i & ~w_empty;
  assign w_wr_acc = bus.wen_i & (~w_full | w_rd_acc);
  assign w_do_rd  = w_rd_acc & ~bus.clear_i;
  assign w_do_wr  = w_wr_acc & ~bus.clear_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
    end else if (bus.clear_i) begin
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
      end
      if (w_do_rd) begin
        r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_valid <= w_do_rd;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_do_wr),
    .waddr_i (r_wr_ptr),
    .wdata_i (bus.data_i),
    .re_i    (w_do_rd),
    .raddr_i (r_rd_ptr),
    .rdata_o (bus.data_o)
  );

  assign bus.valid_o        = r_valid;
  assign bus.cnt_o          = r_cnt;
  assign bus.empty_o        = w_empty;
  assign bus.full_o         = w_full;
  assign bus.almost_full_o  = (r_cnt >= bus.afull_thr_i);
  assign bus.almost_empty_o = (r_cnt <= bus.aempty_thr_i);

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error event takes priority over a same-cycle clear request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wen_i & ~w_wr_acc & ~bus.clear_i) begin
        r_overflow <= 1'b1;
      end else if (bus.err_clr_i) begin
        r_overflow <= 1'b0;
      end
      if (bus.ren_i & w_empty & ~bus.clear_i) begin
        r_underflow <= 1'b1;
      end else if (bus.err_clr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.overflow_o  = r_overflow;
  assign bus.underflow_o = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr_i;
  assign bus.overflow_o   = 1'b0;
  assign bus.underflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog (DEPTH=5) against a queue-based reference model.
module tb_fifo_sync_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fifo_sync_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_sync_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  function automatic void model_reset();
    m_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endfunction

  function automatic logic [17:0] exp_vec();
    int  n;
    logic eo, eu;
    n = m_q.size();
`ifdef FIFO_ERR_FLAGS_EN
    eo = m_ovf;
    eu = m_unf;
`else
    eo = 1'b0;
    eu = 1'b0;
`endif
    return {CW'(n), (n == DEPTH), (n == 0), (n >= int'(bus.afull_thr_i)),
            (n <= int'(bus.aempty_thr_i)), m_valid, m_data, eo, eu};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.cnt_o, bus.full_o, bus.empty_o, bus.almost_full_o, bus.almost_empty_o,
            bus.valid_o, bus.data_o, bus.overflow_o, bus.underflow_o};
  endfunction

  // Drive one cycle, advance the model by the FIFO's rules, sample #1 after the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic e);
    int  n;
    logic rd, wr;
    n  = m_q.size();
    rd = r && (n != 0);
    wr = w && ((n != DEPTH) || rd);
    bus.wen_i     = w;
    bus.data_i    = d;
    bus.ren_i     = r;
    bus.clear_i   = c;
    bus.err_clr_i = e;
    if (e) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (c) begin
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      if (w && !wr) m_ovf = 1'b1;
      if (r && n == 0) m_unf = 1'b1;
      m_valid = rd;
      if (rd) m_data = m_q.pop_front();
      if (wr) m_q.push_back(d);
    end
    @(posedge clk);
    #1;
    bus.wen_i     = 1'b0;
    bus.ren_i     = 1'b0;
    bus.clear_i   = 1'b0;
    bus.err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.wen_i        = 1'b0;
    bus.ren_i        = 1'b0;
    bus.clear_i      = 1'b0;
    bus.err_clr_i    = 1'b0;
    bus.data_i       = '0;
    bus.afull_thr_i  = 3'd4;
    bus.aempty_thr_i = 3'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obs_vec() !== 18'b000_0101_0_00000000_00) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", obs_vec(), 18'b000_0101_0_00000000_00);
    end
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 6; i++) begin
      step(1, 8'h11 + 8'(i), 0, 0, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 0, 0);
      n_tests++;
      if (bus.data_o !== 8'h11 + 8'(i) || bus.valid_o !== 1'b1 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    step(0, 8'h00, 0, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL drain_idle: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    int writes;
    writes = 0;
    repeat (2) begin
      step(1, 8'($urandom), 0, 0, 0);
      writes++;
    end
    while (writes < 12) begin
      step(1, 8'($urandom), (m_q.size() == 3) ? 1'b1 : 1'($urandom), 0, 0);
      writes++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h want %h", writes, obs_vec(), exp_vec());
      end
    end
    while (m_q.size() != 0) begin
      step(0, 8'h00, 1, 0, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_drain: got %h want %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_simul_full();
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'h31 + 8'(i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    n_tests++;
    if (bus.cnt_o !== 3'd5 || bus.overflow_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL simul_full: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'h00, 1, 0, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul_full_drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (bus.data_o !== 8'hAA) begin
      n_fail++;
      $display("FAIL simul_full_last: got %h want %h", bus.data_o, 8'hAA);
    end
  endtask

  task automatic test_simul_empty();
    step(1, 8'h5C, 1, 0, 0);
    n_tests++;
    if (bus.cnt_o !== 3'd1 || bus.valid_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL simul_empty: got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 8'h00, 1, 0, 0);
    n_tests++;
    if (bus.data_o !== 8'h5C || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL simul_empty_read: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_clear_errclr();
    for (int i = 0; i < 3; i++) step(1, 8'h71 + 8'(i), 0, 0, 0);
    step(1, 8'h99, 0, 1, 0);
    n_tests++;
    if (bus.cnt_o !== 3'd0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL clear: got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 8'h00, 1, 0, 1);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL errclr_set_wins: got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 8'h00, 0, 0, 1);
    n_tests++;
    if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL errclr: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) step(1, 8'h81 + 8'(i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    bus.wen_i  = 1'b1;
    bus.ren_i  = 1'b1;
    bus.data_i = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
    end
    bus.wen_i = 1'b0;
    bus.ren_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL after_reset: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.afull_thr_i  = CW'($urandom_range(0, 7));
      bus.aempty_thr_i = CW'($urandom_range(0, 7));
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 5));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_clear_errclr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
